// File: rtl/mem.sv
// -----------------------------------------------------------------------------
// mem -- pipeline memory stage with a byte-addressed, little-endian data memory.
//
// Loads and stores of byte / halfword / word size. The load result and the
// error flag are registered, so a load returns one cycle after it is presented.
// Misaligned accesses, the reserved size code and simultaneous load+store
// requests are flagged on o_mem_error and never modify memory. A combinational
// debug port reads any aligned word without disturbing the pipeline.
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_reset         asynchronous active-high reset: clears outputs and memory
//   i_enable        stage enable; 0 stalls memory and output registers
//   i_mem_wr        store request
//   i_mem_rd        load request
//   i_mem_size      00 byte, 01 halfword, 11 word, 10 reserved (illegal)
//   i_mem_unsigned  1 = zero-extend loads, 0 = sign-extend
//   i_alu_result    effective byte address (upper bits beyond ADDR_W ignored)
//   i_sc_bus_b      store data
//   i_debug_addr    debug word read address (low two bits ignored)
//   o_mem_rd_data   registered, extended load result
//   o_mem_error     registered illegal-access flag
//   o_debug_data    combinational word at the debug address
// -----------------------------------------------------------------------------
module mem #(
   parameter int  BUS_SIZE          = 32,
   parameter int  MEM_SIZE_IN_BYTES = 256,
   localparam int ADDR_W            = $clog2(MEM_SIZE_IN_BYTES)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_mem_wr,
   input  logic                i_mem_rd,
   input  logic [1:0]          i_mem_size,
   input  logic                i_mem_unsigned,
   input  logic [BUS_SIZE-1:0] i_alu_result,
   input  logic [BUS_SIZE-1:0] i_sc_bus_b,
   input  logic [ADDR_W-1:0]   i_debug_addr,
   output logic [BUS_SIZE-1:0] o_mem_rd_data,
   output logic                o_mem_error,
   output logic [BUS_SIZE-1:0] o_debug_data
);

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_RSVD = 2'b10,
      SIZE_WORD = 2'b11
   } size_t;

   logic [7:0] mem_q [MEM_SIZE_IN_BYTES];

   size_t             size;
   logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
   logic [7:0]        byte0, byte1, byte2, byte3;
   logic              aligned;
   logic              access_error;
   logic              do_store;
   logic              do_load;
   logic [BUS_SIZE-1:0] load_val;

   // Address bits above ADDR_W are intentionally dropped (addresses wrap), as
   // are store-data bits above 31 and the debug address byte offset.
   logic unused_bits;
   assign unused_bits = ^{i_alu_result, i_sc_bus_b, i_debug_addr[1:0]};

   assign size  = size_t'(i_mem_size);
   assign addr0 = i_alu_result[ADDR_W-1:0];
   assign addr1 = addr0 + ADDR_W'(1);
   assign addr2 = addr0 + ADDR_W'(2);
   assign addr3 = addr0 + ADDR_W'(3);

   assign byte0 = mem_q[addr0];
   assign byte1 = mem_q[addr1];
   assign byte2 = mem_q[addr2];
   assign byte3 = mem_q[addr3];

   // Alignment legality by access size; the reserved size is never legal.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      aligned = 1'b0;
      case (size)
         SIZE_BYTE: aligned = 1'b1;
         SIZE_HALF: aligned = (addr0[0] == 1'b0);
         SIZE_WORD: aligned = (addr0[1:0] == 2'b00);
         default:   aligned = 1'b0;
      endcase
   end

   // A request of both kinds at once is an error even when aligned; an idle
   // cycle (no request) is never an error.
   assign access_error = (i_mem_wr | i_mem_rd) & ((i_mem_wr & i_mem_rd) | ~aligned);
   assign do_store     = i_enable & i_mem_wr & ~i_mem_rd & aligned;
   assign do_load      = i_enable & i_mem_rd & ~i_mem_wr & aligned;

   always_comb begin
      load_val = '0;
      case (size)
         SIZE_BYTE: load_val = i_mem_unsigned ? BUS_SIZE'(byte0)
                                              : {{(BUS_SIZE-8){byte0[7]}}, byte0};
         SIZE_HALF: load_val = i_mem_unsigned ? BUS_SIZE'({byte1, byte0})
                                              : {{(BUS_SIZE-16){byte1[7]}}, byte1, byte0};
         SIZE_WORD: load_val = BUS_SIZE'({byte3, byte2, byte1, byte0});
         default:   load_val = '0;
      endcase
   end

   // NOTE: the memory is reset byte by byte, so it maps to flops rather than a
   // RAM macro; a reset edge also wins over any store presented on that edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < MEM_SIZE_IN_BYTES; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (do_store) begin
         // NOTE: non-blocking assignments keep sequential state updates ordered
         // independently of statement order.
         mem_q[addr0] <= i_sc_bus_b[7:0];
         if (size != SIZE_BYTE) begin
            mem_q[addr1] <= i_sc_bus_b[15:8];
         end
         if (size == SIZE_WORD) begin
            mem_q[addr2] <= i_sc_bus_b[23:16];
            mem_q[addr3] <= i_sc_bus_b[31:24];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_mem_rd_data <= '0;
         o_mem_error   <= 1'b0;
      end else if (i_enable) begin
         if (access_error) begin
            o_mem_rd_data <= '0;
            o_mem_error   <= 1'b1;
         end else begin
            o_mem_error <= 1'b0;
            if (do_load) begin
               o_mem_rd_data <= load_val;
            end
         end
      end
   end

   assign o_debug_data = BUS_SIZE'({mem_q[{i_debug_addr[ADDR_W-1:2], 2'b11}],
                                    mem_q[{i_debug_addr[ADDR_W-1:2], 2'b10}],
                                    mem_q[{i_debug_addr[ADDR_W-1:2], 2'b01}],
                                    mem_q[{i_debug_addr[ADDR_W-1:2], 2'b00}]});

endmodule

// File: tb/tb_mem.sv
// -----------------------------------------------------------------------------
// tb_mem -- self-checking bench for mem (BUS_SIZE=32, 256-byte memory).
// Table of directed vectors applied one per clock, plus hand-written sequences
// for reset, stall-hold of the error flag and asynchronous reset mid-store.
// -----------------------------------------------------------------------------
module tb_mem;

   localparam int BUS_SIZE = 32;
   localparam int MEM_SIZE = 256;
   localparam int ADDR_W   = 8;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic                i_enable;
   logic                i_mem_wr;
   logic                i_mem_rd;
   logic [1:0]          i_mem_size;
   logic                i_mem_unsigned;
   logic [BUS_SIZE-1:0] i_alu_result;
   logic [BUS_SIZE-1:0] i_sc_bus_b;
   logic [ADDR_W-1:0]   i_debug_addr;
   logic [BUS_SIZE-1:0] o_mem_rd_data;
   logic                o_mem_error;
   logic [BUS_SIZE-1:0] o_debug_data;

   mem #(.BUS_SIZE(BUS_SIZE), .MEM_SIZE_IN_BYTES(MEM_SIZE)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_enable       (i_enable),
      .i_mem_wr       (i_mem_wr),
      .i_mem_rd       (i_mem_rd),
      .i_mem_size     (i_mem_size),
      .i_mem_unsigned (i_mem_unsigned),
      .i_alu_result   (i_alu_result),
      .i_sc_bus_b     (i_sc_bus_b),
      .i_debug_addr   (i_debug_addr),
      .o_mem_rd_data  (o_mem_rd_data),
      .o_mem_error    (o_mem_error),
      .o_debug_data   (o_debug_data)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic        en;
      logic        wr;
      logic        rd;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  dbg_addr;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] exp_dbg;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic wr, input logic rd, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] dbg);
      i_enable       = en;
      i_mem_wr       = wr;
      i_mem_rd       = rd;
      i_mem_size     = size;
      i_mem_unsigned = uns;
      i_alu_result   = addr;
      i_sc_bus_b     = wdata;
      i_debug_addr   = dbg;
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic en, input logic wr, input logic rd,
                               input logic [1:0] size, input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [7:0] dbg,
                               input logic [31:0] exp_rd, input logic exp_err,
                               input logic [31:0] exp_dbg);
      vec_t v;
      v.name = name; v.en = en; v.wr = wr; v.rd = rd; v.size = size; v.uns = uns;
      v.addr = addr; v.wdata = wdata; v.dbg_addr = dbg;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_dbg = exp_dbg;
      return v;
   endfunction

   initial begin
      //                 name            en wr rd size  uns addr          wdata         dbg    exp_rd        err  exp_dbg
      vecs.push_back(mk("st_w_10",       1, 1, 0, 2'b11, 0, 32'h10,        32'hDEADBEEF, 8'h10, 32'h0,        0, 32'hDEADBEEF));
      vecs.push_back(mk("ld_w_10",       1, 0, 1, 2'b11, 0, 32'h10,        32'h0,        8'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF));
      vecs.push_back(mk("st_b_12",       1, 1, 0, 2'b00, 0, 32'h12,        32'hAAAAAA7F, 8'h10, 32'hDEADBEEF, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_bs_13",      1, 0, 1, 2'b00, 0, 32'h13,        32'h0,        8'h10, 32'hFFFFFFDE, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_hu_12",      1, 0, 1, 2'b01, 1, 32'h12,        32'h0,        8'h10, 32'h0000DE7F, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_w_10b",      1, 0, 1, 2'b11, 0, 32'h10,        32'h0,        8'h13, 32'hDE7FBEEF, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_hs_10",      1, 0, 1, 2'b01, 0, 32'h10,        32'h0,        8'h10, 32'hFFFFBEEF, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_bu_11",      1, 0, 1, 2'b00, 1, 32'h11,        32'h0,        8'h10, 32'h000000BE, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("st_w_11_mis",   1, 1, 0, 2'b11, 0, 32'h11,        32'h12345678, 8'h10, 32'h0,        1, 32'hDE7FBEEF));
      vecs.push_back(mk("idle_clr_err",  1, 0, 0, 2'b11, 0, 32'h10,        32'h0,        8'h10, 32'h0,        0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_w_10c",      1, 0, 1, 2'b11, 0, 32'h10,        32'h0,        8'h10, 32'hDE7FBEEF, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_h_03_mis",   1, 0, 1, 2'b01, 0, 32'h03,        32'h0,        8'h00, 32'h0,        1, 32'h0));
      vecs.push_back(mk("ld_size10",     1, 0, 1, 2'b10, 0, 32'h10,        32'h0,        8'h10, 32'h0,        1, 32'hDE7FBEEF));
      vecs.push_back(mk("rd_and_wr",     1, 1, 1, 2'b11, 0, 32'h10,        32'h0,        8'h10, 32'h0,        1, 32'hDE7FBEEF));
      vecs.push_back(mk("st_w_104_wrap", 1, 1, 0, 2'b11, 0, 32'h104,       32'hCAFEF00D, 8'h04, 32'h0,        0, 32'hCAFEF00D));
      vecs.push_back(mk("st_w_stalled",  0, 1, 0, 2'b11, 0, 32'h10,        32'h11111111, 8'h10, 32'h0,        0, 32'hDE7FBEEF));
      vecs.push_back(mk("ld_w_204_wrap", 1, 0, 1, 2'b11, 0, 32'h204,       32'h0,        8'h04, 32'hCAFEF00D, 0, 32'hCAFEF00D));
      vecs.push_back(mk("ld_w_stalled",  0, 0, 1, 2'b11, 0, 32'h10,        32'h0,        8'h10, 32'hCAFEF00D, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("mis_stalled",   0, 1, 0, 2'b11, 0, 32'h13,        32'h0,        8'h10, 32'hCAFEF00D, 0, 32'hDE7FBEEF));
      vecs.push_back(mk("st_h_22",       1, 1, 0, 2'b01, 0, 32'h22,        32'h1234ABCD, 8'h20, 32'hCAFEF00D, 0, 32'hABCD0000));
      vecs.push_back(mk("st_b_21",       1, 1, 0, 2'b00, 0, 32'hFFFFFF21,  32'hFFFFFF80, 8'h20, 32'hCAFEF00D, 0, 32'hABCD8000));
      vecs.push_back(mk("ld_bs_21",      1, 0, 1, 2'b00, 0, 32'h21,        32'h0,        8'h20, 32'hFFFFFF80, 0, 32'hABCD8000));
      vecs.push_back(mk("ld_w_20_uns",   1, 0, 1, 2'b11, 1, 32'h20,        32'h0,        8'h20, 32'hABCD8000, 0, 32'hABCD8000));

      // Reset state.
      i_reset = 1'b1;
      drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 8'h10);
      @(posedge i_clk); #2;
      check("reset_rd_data", o_mem_rd_data, 32'h0);
      check("reset_error",   {31'h0, o_mem_error}, 32'h0);
      check("reset_debug",   o_debug_data, 32'h0);
      i_reset = 1'b0;

      // Table-driven vectors, one per clock, sampled 1 time unit after the edge.
      foreach (vecs[k]) begin
         drive(vecs[k].en, vecs[k].wr, vecs[k].rd, vecs[k].size, vecs[k].uns,
               vecs[k].addr, vecs[k].wdata, vecs[k].dbg_addr);
         @(posedge i_clk); #1;
         check({vecs[k].name, ".rd_data"}, o_mem_rd_data, vecs[k].exp_rd);
         check({vecs[k].name, ".error"},   {31'h0, o_mem_error}, {31'h0, vecs[k].exp_err});
         check({vecs[k].name, ".debug"},   o_debug_data, vecs[k].exp_dbg);
      end

      // Error flag holds through a stall.
      drive(1, 0, 1, 2'b10, 0, 32'h20, 32'h0, 8'h20);
      @(posedge i_clk); #1;
      check("err_set.error", {31'h0, o_mem_error}, 32'h1);
      drive(0, 0, 1, 2'b11, 0, 32'h20, 32'h0, 8'h20);
      @(posedge i_clk); #1;
      check("err_stall.error",   {31'h0, o_mem_error}, 32'h1);
      check("err_stall.rd_data", o_mem_rd_data, 32'h0);

      // Load a nonzero value, then assert reset between edges with a store pending.
      drive(1, 0, 1, 2'b11, 0, 32'h20, 32'h0, 8'h20);
      @(posedge i_clk); #1;
      check("pre_rst.rd_data", o_mem_rd_data, 32'hABCD8000);
      drive(1, 1, 0, 2'b11, 0, 32'h30, 32'h55AA55AA, 8'h20);
      #2 i_reset = 1'b1;
      #1;
      check("async_rst.rd_data", o_mem_rd_data, 32'h0);
      check("async_rst.error",   {31'h0, o_mem_error}, 32'h0);
      check("async_rst.debug20", o_debug_data, 32'h0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      drive(1, 0, 0, 2'b11, 0, 32'h30, 32'h0, 8'h30);
      #1;
      check("rst_no_write.debug30", o_debug_data, 32'h0);
      i_debug_addr = 8'h10;
      #1;
      check("rst_cleared.debug10", o_debug_data, 32'h0);

      // First legal access after reset release is accepted on the next edge.
      drive(1, 1, 0, 2'b11, 0, 32'h30, 32'h01020304, 8'h30);
      @(posedge i_clk); #1;
      check("post_rst_st.debug30", o_debug_data, 32'h01020304);
      drive(1, 0, 1, 2'b01, 0, 32'h32, 32'h0, 8'h30);
      @(posedge i_clk); #1;
      check("post_rst_ld_hs_32.rd_data", o_mem_rd_data, 32'h00000102);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
